// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: background/test-pattern generator plus priority overlay mux
// feeding the RGB pins through a fixed 2-stage pipeline. Mode, layer enables and blink
// enables only change at pixel (0,0) so a frame is never torn.
module vga_layer_compositor #(
    parameter logic [9:0]  H_DISP       = 10'd640,
    parameter logic [9:0]  V_DISP       = 10'd480,
    parameter int unsigned NUM_LAYERS   = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                       vga_clk_i,
    input  logic                       sys_rst_n_i,
    input  logic [9:0]                 pixel_xpos_i,
    input  logic [9:0]                 pixel_ypos_i,
    input  logic [1:0]                 mode_sel_i,
    input  logic [NUM_LAYERS-1:0]      layer_en_i,
    input  logic [NUM_LAYERS-1:0]      blink_en_i,
    input  logic [24*NUM_LAYERS-1:0]   layer_data_i,
    input  logic [NUM_LAYERS-1:0]      layer_valid_i,
    output logic [23:0]                pixel_data_o,
    output logic                       frame_start_o
);

    localparam int unsigned    CntW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_FRAMES - 1);
    localparam logic [9:0]     BarW   = H_DISP / 10'd8;

    // Frame-synchronous configuration and blink state
    logic                  fb;
    logic [1:0]            mode_q, mode_d;
    logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
    logic [NUM_LAYERS-1:0] blink_en_q, blink_en_d;
    logic [CntW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    // Stage 1
    logic [2:0]               bar_idx;
    logic [23:0]              bar_col;
    logic [23:0]              bg_d, bg_q;
    logic [NUM_LAYERS-1:0]    vis_d, vis_q;
    logic [24*NUM_LAYERS-1:0] ldata_q;
    logic                     in_disp_d, in_disp_q;
    logic                     fs_q;

    // Stage 2
    logic [23:0] pix_d;

    // Next-state of the config registers; the _d values double as the bypass at (0,0)
    always_comb begin
        fb            = (pixel_xpos_i == 10'd0) && (pixel_ypos_i == 10'd0);
        mode_d        = mode_q;
        layer_en_d    = layer_en_q;
        blink_en_d    = blink_en_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (fb) begin
            mode_d     = mode_sel_i;
            layer_en_d = layer_en_i;
            blink_en_d = blink_en_i;
            if (frame_cnt_q == CntMax) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CntW'(1);
            end
        end
    end

    // Config and blink registers
    always_ff @(posedge vga_clk_i) begin
        if (!sys_rst_n_i) begin
            mode_q        <= 2'd0;
            layer_en_q    <= '0;
            blink_en_q    <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            layer_en_q    <= layer_en_d;
            blink_en_q    <= blink_en_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Background colour, display window and per-layer visibility for this pixel
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (pixel_xpos_i >= 10'(k) * BarW) begin
                bar_idx = 3'(k);
            end
        end
        unique case (bar_idx)
            3'd0:    bar_col = 24'hFFFFFF;
            3'd1:    bar_col = 24'hFFFF00;
            3'd2:    bar_col = 24'h00FFFF;
            3'd3:    bar_col = 24'h00FF00;
            3'd4:    bar_col = 24'hFF00FF;
            3'd5:    bar_col = 24'hFF0000;
            3'd6:    bar_col = 24'h0000FF;
            default: bar_col = 24'h000000;
        endcase
        unique case (mode_d)
            2'd0:    bg_d = 24'h000000;
            2'd1:    bg_d = 24'hFFFFFF;
            2'd2:    bg_d = bar_col;
            default: bg_d = (pixel_xpos_i[5] ^ pixel_ypos_i[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
        in_disp_d = (pixel_xpos_i < H_DISP) && (pixel_ypos_i < V_DISP);
        vis_d     = layer_en_d & layer_valid_i & ~(blink_en_d & {NUM_LAYERS{blink_phase_d}});
    end

    // Stage 1 registers
    always_ff @(posedge vga_clk_i) begin
        if (!sys_rst_n_i) begin
            bg_q      <= 24'h000000;
            ldata_q   <= '0;
            vis_q     <= '0;
            in_disp_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            bg_q      <= bg_d;
            ldata_q   <= layer_data_i;
            vis_q     <= vis_d;
            in_disp_q <= in_disp_d;
            fs_q      <= fb;
        end
    end

    // Priority select: later (higher-index) visible layers override earlier ones
    always_comb begin
        pix_d = bg_q;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (vis_q[i]) begin
                pix_d = ldata_q[24*i +: 24];
            end
        end
        if (!in_disp_q) begin
            pix_d = 24'h000000;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge vga_clk_i) begin
        if (!sys_rst_n_i) begin
            pixel_data_o  <= 24'h000000;
            frame_start_o <= 1'b0;
        end else begin
            pixel_data_o  <= pix_d;
            frame_start_o <= fs_q;
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor: constant vector table, hand-written
// reset/frame-sync/blink sequences, then randomized traffic against a reference model.
module tb_vga_layer_compositor;

    localparam int unsigned NL = 2;
    localparam int unsigned BF = 2;
    localparam int          HD = 640;
    localparam int          VD = 480;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        xpos, ypos;
    logic [1:0]        mode_sel;
    logic [NL-1:0]     layer_en, blink_en, layer_valid;
    logic [24*NL-1:0]  layer_data;
    logic [23:0]       pixel_data;
    logic              frame_start;

    always #5 clk = ~clk;

    vga_layer_compositor #(
        .H_DISP      (10'd640),
        .V_DISP      (10'd480),
        .NUM_LAYERS  (NL),
        .BLINK_FRAMES(BF)
    ) dut (
        .vga_clk_i    (clk),
        .sys_rst_n_i  (rst_n),
        .pixel_xpos_i (xpos),
        .pixel_ypos_i (ypos),
        .mode_sel_i   (mode_sel),
        .layer_en_i   (layer_en),
        .blink_en_i   (blink_en),
        .layer_data_i (layer_data),
        .layer_valid_i(layer_valid),
        .pixel_data_o (pixel_data),
        .frame_start_o(frame_start)
    );

    typedef struct {
        logic [9:0]    x;
        logic [9:0]    y;
        logic [1:0]    mode;
        logic [NL-1:0] en;
        logic [NL-1:0] ben;
        logic [NL-1:0] valid;
        logic [23:0]   d0;
        logic [23:0]   d1;
        logic [23:0]   exp;
    } vec_t;

    vec_t tab[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: config as seen by the current frame
    logic [1:0]    m_mode;
    logic [NL-1:0] m_en, m_ben;
    int            m_nfb;
    logic [23:0]   bar_cols [0:7];

    // Expectations two and one cycle in flight
    logic        e_old_vld = 1'b0, e_new_vld = 1'b0;
    logic [23:0] e_old_pix, e_new_pix;
    logic        e_old_fs, e_new_fs;
    string       e_old_nm, e_new_nm;

    function automatic logic [23:0] model_bg(input logic [1:0] mode, input int x, input int y);
        int b;
        case (mode)
            2'd0: return 24'h000000;
            2'd1: return 24'hFFFFFF;
            2'd2: begin
                b = (x * 8) / HD;
                if (b > 7) b = 7;
                return bar_cols[b];
            end
            default: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    // One pixel clock: check the output for the pixel driven two cycles ago, drive a new one
    task automatic cycle(input logic rst, input logic [9:0] x, input logic [9:0] y,
                         input logic [1:0] mode, input logic [NL-1:0] en,
                         input logic [NL-1:0] ben, input logic [NL-1:0] valid,
                         input logic [23:0] d0, input logic [23:0] d1,
                         input logic use_tab, input logic [23:0] tab_pix, input string nm);
        logic [23:0] mp;
        logic [23:0] ld [0:NL-1];
        int          ph;
        @(negedge clk);
        if (e_old_vld) begin
            n_total++;
            if (pixel_data === e_old_pix) n_pass++;
            else $display("FAIL %s pixel_data got %h want %h", e_old_nm, pixel_data, e_old_pix);
            n_total++;
            if (frame_start === e_old_fs) n_pass++;
            else $display("FAIL %s frame_start got %b want %b", e_old_nm, frame_start, e_old_fs);
        end
        e_old_vld = e_new_vld;
        e_old_pix = e_new_pix;
        e_old_fs  = e_new_fs;
        e_old_nm  = e_new_nm;

        rst_n       = rst;
        xpos        = x;
        ypos        = y;
        mode_sel    = mode;
        layer_en    = en;
        blink_en    = ben;
        layer_valid = valid;
        layer_data  = {d1, d0};
        ld[0]       = d0;
        ld[1]       = d1;

        if (!rst) begin
            m_mode    = 2'd0;
            m_en      = '0;
            m_ben     = '0;
            m_nfb     = 0;
            // The reset edge also wipes the pixel still in flight
            e_old_pix = 24'h000000;
            e_old_fs  = 1'b0;
            e_new_pix = 24'h000000;
            e_new_fs  = 1'b0;
        end else begin
            e_new_fs = (x == 10'd0) && (y == 10'd0);
            if (e_new_fs) begin
                m_nfb++;
                m_mode = mode;
                m_en   = en;
                m_ben  = ben;
            end
            ph = (m_nfb / BF) % 2;
            mp = model_bg(m_mode, int'(x), int'(y));
            for (int i = NL - 1; i >= 0; i--) begin
                if (m_en[i] && valid[i] && !(m_ben[i] && ph == 1)) begin
                    mp = ld[i];
                    break;
                end
            end
            if (!(int'(x) < HD && int'(y) < VD)) mp = 24'h000000;
            e_new_pix = use_tab ? tab_pix : mp;
        end
        e_new_vld = 1'b1;
        e_new_nm  = nm;
    endtask

    initial begin
        logic [23:0] bp;
        bar_cols = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                     24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        m_mode = 2'd0; m_en = '0; m_ben = '0; m_nfb = 0;

        // Colour bars (row 10), priority, blanking, checkerboard
        tab.push_back('{10'd0,   10'd0,   2'd2, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFFFF});
        tab.push_back('{10'd0,   10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFFFF});
        tab.push_back('{10'd79,  10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFFFF});
        tab.push_back('{10'd80,  10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFF00});
        tab.push_back('{10'd160, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h00FFFF});
        tab.push_back('{10'd240, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h00FF00});
        tab.push_back('{10'd320, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFF00FF});
        tab.push_back('{10'd400, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFF0000});
        tab.push_back('{10'd480, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h0000FF});
        tab.push_back('{10'd559, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h0000FF});
        tab.push_back('{10'd560, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h000000});
        tab.push_back('{10'd639, 10'd10,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h000000});
        tab.push_back('{10'd0,   10'd0,   2'd1, 2'b11, 2'b00, 2'b11,
                        24'hFF0000, 24'h0000FF, 24'h0000FF});
        tab.push_back('{10'd5,   10'd5,   2'd0, 2'b00, 2'b00, 2'b11,
                        24'hFF0000, 24'h0000FF, 24'h0000FF});
        tab.push_back('{10'd5,   10'd5,   2'd0, 2'b00, 2'b00, 2'b01,
                        24'hFF0000, 24'h0000FF, 24'hFF0000});
        tab.push_back('{10'd5,   10'd5,   2'd0, 2'b00, 2'b00, 2'b00,
                        24'hFF0000, 24'h0000FF, 24'hFFFFFF});
        tab.push_back('{10'd5,   10'd5,   2'd0, 2'b00, 2'b00, 2'b10,
                        24'hFF0000, 24'h0000FF, 24'h0000FF});
        tab.push_back('{10'd700, 10'd5,   2'd0, 2'b00, 2'b00, 2'b11,
                        24'hFF0000, 24'h0000FF, 24'h000000});
        tab.push_back('{10'd5,   10'd500, 2'd0, 2'b00, 2'b00, 2'b11,
                        24'hFF0000, 24'h0000FF, 24'h000000});
        tab.push_back('{10'd640, 10'd0,   2'd0, 2'b00, 2'b00, 2'b11,
                        24'hFF0000, 24'h0000FF, 24'h000000});
        tab.push_back('{10'd639, 10'd479, 2'd0, 2'b00, 2'b00, 2'b00,
                        24'hFF0000, 24'h0000FF, 24'hFFFFFF});
        tab.push_back('{10'd0,   10'd0,   2'd3, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h000000});
        tab.push_back('{10'd32,  10'd0,   2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFFFF});
        tab.push_back('{10'd32,  10'd32,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h000000});
        tab.push_back('{10'd0,   10'd32,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'hFFFFFF});
        tab.push_back('{10'd31,  10'd31,  2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h000000});

        // Reset held 4 cycles with layers requesting display
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 10'(i), 10'd0, 2'd1, 2'b11, 2'b00, 2'b11, 24'h123456, 24'h654321,
                  1'b1, 24'h000000, "reset_hold");
        // Mid-frame after reset: black background, layers hidden until (0,0)
        cycle(1'b1, 10'd3, 10'd3, 2'd1, 2'b11, 2'b00, 2'b11, 24'h123456, 24'h654321,
              1'b1, 24'h000000, "post_reset_midframe");
        cycle(1'b1, 10'd0, 10'd0, 2'd1, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'hFFFFFF, "first_frame_origin");
        cycle(1'b1, 10'd10, 10'd10, 2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'hFFFFFF, "first_frame_body");

        // Mode change mid-frame must wait for the next (0,0)
        cycle(1'b1, 10'd100, 10'd50, 2'd3, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'hFFFFFF, "sync_midframe");
        cycle(1'b1, 10'd40, 10'd0, 2'd3, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'hFFFFFF, "sync_same_frame");
        cycle(1'b1, 10'd0, 10'd0, 2'd3, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'h000000, "sync_new_origin");
        cycle(1'b1, 10'd32, 10'd0, 2'd1, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'hFFFFFF, "sync_checker");
        cycle(1'b1, 10'd33, 10'd40, 2'd1, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'h000000, "sync_checker_diag");

        foreach (tab[i])
            cycle(1'b1, tab[i].x, tab[i].y, tab[i].mode, tab[i].en, tab[i].ben, tab[i].valid,
                  tab[i].d0, tab[i].d1, 1'b1, tab[i].exp, $sformatf("tab%0d", i));

        // Blink with a 2-frame half-period: phase flips on every second frame boundary
        cycle(1'b0, 10'd9, 10'd9, 2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b1, 24'h000000, "blink_reset");
        for (int f = 0; f < 6; f++) begin
            bp = (f == 1 || f == 2 || f == 5) ? 24'h000000 : 24'h123456;
            cycle(1'b1, 10'd0, 10'd0, 2'd0, 2'b01, 2'b01, 2'b01, 24'h123456, 24'h0,
                  1'b1, bp, $sformatf("blink_f%0d_origin", f));
            cycle(1'b1, 10'd8, 10'd8, 2'd0, 2'b00, 2'b00, 2'b01, 24'h123456, 24'h0,
                  1'b1, bp, $sformatf("blink_f%0d_body", f));
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic        r, org;
            logic [9:0]  rx, ry;
            r   = ($urandom_range(0, 199) != 0);
            org = ($urandom_range(0, 15) == 0);
            rx  = org ? 10'd0 : 10'($urandom_range(0, 719));
            ry  = org ? 10'd0 : 10'($urandom_range(0, 529));
            cycle(r, rx, ry, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  24'($urandom), 24'($urandom), 1'b0, 24'h0, $sformatf("rand%0d", n));
        end
        // Drain the pipeline
        cycle(1'b1, 10'd700, 10'd0, 2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b0, 24'h0, "drain0");
        cycle(1'b1, 10'd700, 10'd0, 2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b0, 24'h0, "drain1");
        cycle(1'b1, 10'd700, 10'd0, 2'd0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0,
              1'b0, 24'h0, "drain2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
